cpu_ctrl_fsm: RTL

- Multicycle control unit for the 16-bit bus-based CPU.
- Sits directly upstream of the ALU stage (A register, adder/subtractor, G register). Drives that stage's ain, gin and sub controls, the register-file load enables, and the one-hot bus source selects.
- Latches a 9-bit instruction from din, then sequences it through timesteps T0..T3.
- Pulses done when the instruction completes.

---
 rtl/cpu_ctrl_fsm_pkg.sv | 34 +++
 rtl/cpu_ctrl_fsm_if.sv | 31 +++
 rtl/cpu_ctrl_fsm_dec3to8.sv | 18 +
 rtl/cpu_ctrl_fsm.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_fsm_pkg.sv
// Shared constants for the multicycle CPU control unit: opcodes, timestep
// encoding and instruction field positions.
package cpu_ctrl_pkg;

  // Instruction word width taken from the low bits of din.
  localparam int IR_W = 9;

  // Instruction field positions: IR[8:6]=op, IR[5:3]=X, IR[2:0]=Y.
  localparam int OP_MSB = 8;
  localparam int OP_LSB = 6;
  localparam int X_MSB  = 5;
  localparam int X_LSB  = 3;
  localparam int Y_MSB  = 2;
  localparam int Y_LSB  = 0;

  // Opcodes; 101..111 fall through to nop.
  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_MVNZ = 3'b100;

  // Timestep encoding.
  localparam logic [1:0] T0 = 2'd0;
  localparam logic [1:0] T1 = 2'd1;
  localparam logic [1:0] T2 = 2'd2;
  localparam logic [1:0] T3 = 2'd3;

  // True for the opcodes that use the A/G datapath over T1..T3.
  function automatic logic is_alu_op(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/cpu_ctrl_fsm_if.sv
// Handshake and control bundle between the control FSM (master) and the
// datapath / environment (slave).
interface cpu_ctrl_fsm_if #(
  parameter int DATA_W = 16,
  parameter int NREG   = 8
) ();

  logic              run;
  logic [DATA_W-1:0] din;
  logic              g_nz;
  logic              irin;
  logic [NREG-1:0]   rin;
  logic [NREG-1:0]   rout;
  logic              gout;
  logic              dinout;
  logic              ain;
  logic              gin;
  logic              sub;
  logic              done;

  modport master (
    input  run, din, g_nz,
    output irin, rin, rout, gout, dinout, ain, gin, sub, done
  );

  modport slave (
    output run, din, g_nz,
    input  irin, rin, rout, gout, dinout, ain, gin, sub, done
  );

endinterface

// File: rtl/cpu_ctrl_fsm_dec3to8.sv
// 3-bit to one-hot 8 decoder with enable; output is all-zero when disabled.
module dec3to8 (
  input  logic       en_i,
  input  logic [2:0] sel_i,
  output logic [7:0] y_o
);

  // One-hot decode of sel_i, gated by en_i.
  always_comb begin
    y_o = 8'b0000_0000;
    if (en_i) begin
      y_o[sel_i] = 1'b1;
    end else begin
      y_o = 8'b0000_0000;
    end
  end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multicycle control unit for the 16-bit bus CPU. Fetches a 9-bit
// instruction in T0 and sequences it over T1..T3, driving register-file,
// bus-select and ALU-stage controls. Outputs are combinational from the
// timestep, IR and run, and are forced low while resetn is low.
// Optional feature macro: CPU_CTRL_MVNZ_EN enables the conditional mvnz op.
module cpu_ctrl_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NREG   = 8
) (
  input  logic          clk,
  input  logic          resetn,
  cpu_ctrl_fsm_if.master bus
);

  logic [1:0]      state_q, state_d;
  logic [IR_W-1:0] ir_q, ir_d;

  logic [2:0] op_s, x_s, y_s;
  logic [2:0] rout_sel_s;
  logic       rin_en_s, rout_en_s;
  logic       irin_s, gout_s, dinout_s, ain_s, gin_s, sub_s, done_s;
  logic [7:0] rin_oh_s, rout_oh_s;
  logic       unused_s;

  assign op_s = ir_q[OP_MSB:OP_LSB];
  assign x_s  = ir_q[X_MSB:X_LSB];
  assign y_s  = ir_q[Y_MSB:Y_LSB];

`ifdef CPU_CTRL_MVNZ_EN
  assign unused_s = ^bus.din[DATA_W-1:IR_W];
`else
  assign unused_s = ^{bus.din[DATA_W-1:IR_W], bus.g_nz};
`endif

  // Timestep and IR registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= T0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // Next-state and control decode; everything stays low during reset.
  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    irin_s     = 1'b0;
    rin_en_s   = 1'b0;
    rout_en_s  = 1'b0;
    rout_sel_s = y_s;
    gout_s     = 1'b0;
    dinout_s   = 1'b0;
    ain_s      = 1'b0;
    gin_s      = 1'b0;
    sub_s      = 1'b0;
    done_s     = 1'b0;
    if (resetn) begin
      case (state_q)
        T0: begin
          irin_s = 1'b1;
          if (bus.run) begin
            ir_d    = bus.din[IR_W-1:0];
            state_d = T1;
          end else begin
            state_d = T0;
          end
        end
        T1: begin
          case (op_s)
            OP_MV: begin
              rout_en_s = 1'b1;
              rin_en_s  = 1'b1;
              done_s    = 1'b1;
              state_d   = T0;
            end
            OP_MVI: begin
              dinout_s = 1'b1;
              rin_en_s = 1'b1;
              done_s   = 1'b1;
              state_d  = T0;
            end
            OP_ADD, OP_SUB: begin
              rout_sel_s = x_s;
              rout_en_s  = 1'b1;
              ain_s      = 1'b1;
              state_d    = T2;
            end
`ifdef CPU_CTRL_MVNZ_EN
            OP_MVNZ: begin
              if (bus.g_nz) begin
                rout_en_s = 1'b1;
                rin_en_s  = 1'b1;
              end else begin
                rout_en_s = 1'b0;
                rin_en_s  = 1'b0;
              end
              done_s  = 1'b1;
              state_d = T0;
            end
`endif
            default: begin
              done_s  = 1'b1;
              state_d = T0;
            end
          endcase
        end
        T2: begin
          if (is_alu_op(op_s)) begin
            rout_en_s = 1'b1;
            gin_s     = 1'b1;
            sub_s     = (op_s == OP_SUB);
            state_d   = T3;
          end else begin
            // Unreachable for a legal sequence; recover to fetch.
            state_d = T0;
          end
        end
        T3: begin
          if (is_alu_op(op_s)) begin
            gout_s   = 1'b1;
            rin_en_s = 1'b1;
            done_s   = 1'b1;
          end else begin
            done_s = 1'b0;
          end
          state_d = T0;
        end
        default: begin
          state_d = T0;
        end
      endcase
    end else begin
      state_d = T0;
      ir_d    = '0;
    end
  end

  dec3to8 u_rin_dec (
    .en_i  (rin_en_s),
    .sel_i (x_s),
    .y_o   (rin_oh_s)
  );

  dec3to8 u_rout_dec (
    .en_i  (rout_en_s),
    .sel_i (rout_sel_s),
    .y_o   (rout_oh_s)
  );

  assign bus.irin   = irin_s;
  assign bus.rin    = rin_oh_s;
  assign bus.rout   = rout_oh_s;
  assign bus.gout   = gout_s;
  assign bus.dinout = dinout_s;
  assign bus.ain    = ain_s;
  assign bus.gin    = gin_s;
  assign bus.sub    = sub_s;
  assign bus.done   = done_s;

endmodule
